// File: rtl/digital_scan_ctrl.sv
// digital_scan_ctrl
//   Scan scheduler for a multiplexed common-anode 7-segment display.
//   Lights DIGITS digits in turn for DWELL cycles each, then holds all
//   selects off for BLANK anti-ghost cycles. A 4-bit PWM dims the segments,
//   completed frames are counted, and a CPU-visible CTRL/STATUS pair is
//   exposed on a one-bit word address.
//
// Ports
//   clk             in   1   system clock
//   reset           in   1   synchronous, active-high
//   enable          in   1   bus write strobe for this block
//   Addr            in   1   word select: 0 = CTRL, 1 = STATUS (read-only)
//   data_in         in  32   write data; CTRL uses bit0 = en, bits[7:4] = duty
//   data_return_cpu out 32   read data, combinational on Addr
//   digit_idx       out  3   digit currently being scanned
//   digit_sel       out  8   one-hot digit select, all zero while blanking/idle
//   seg_on          out  1   segment enable for the code datapath (PWM gated)
//   frame_tick      out  1   one-cycle pulse when the scan wraps to digit 0

module digital_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 20,
    parameter int unsigned BLANK  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        Addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_return_cpu,
    output logic [2:0]  digit_idx,
    output logic [7:0]  digit_sel,
    output logic        seg_on,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_BLK  = 2'd2
    } state_e;

    localparam logic [2:0]  LAST_IDX   = 3'(DIGITS - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LAST = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;
    localparam bit          HAS_BLANK  = (BLANK > 0);

    // CPU control register
    logic        en_q, en_d;
    logic [3:0]  duty_q, duty_d;

    // Scan sequencer
    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] blank_q, blank_d;
    logic [3:0]  pwm_q, pwm_d;
    logic [3:0]  duty_sh_q, duty_sh_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Registered outputs
    logic [7:0]  digit_sel_q, digit_sel_d;
    logic        seg_on_q, seg_on_d;
    logic        frame_tick_q, frame_tick_d;

    logic        advance;
    logic        go_idle;

    always_comb begin
        // NOTE: every _d starts from its hold value so no branch of the case below can infer a latch.
        en_d         = en_q;
        duty_d       = duty_q;
        state_d      = state_q;
        idx_d        = idx_q;
        dwell_d      = dwell_q;
        blank_d      = blank_q;
        pwm_d        = pwm_q;
        duty_sh_d    = duty_sh_q;
        frame_cnt_d  = frame_cnt_q;
        frame_tick_d = 1'b0;
        advance      = 1'b0;
        go_idle      = 1'b0;

        // The write lands this edge; the sequencer below still steers from the
        // pre-write en_q/duty_q, so a write acts one cycle later.
        if (enable && !Addr) begin
            en_d   = data_in[0];
            duty_d = data_in[7:4];
        end

        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d   = ST_ON;
                    idx_d     = 3'd0;
                    dwell_d   = 16'd0;
                    pwm_d     = 4'd0;
                    duty_sh_d = duty_q;
                end
            end
            ST_ON: begin
                if (!en_q) begin
                    go_idle = 1'b1;
                end else if (dwell_q == DWELL_LAST) begin
                    if (HAS_BLANK) begin
                        state_d = ST_BLK;
                        blank_d = 16'd0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                    pwm_d   = pwm_q + 4'd1;
                end
            end
            ST_BLK: begin
                if (!en_q) begin
                    go_idle = 1'b1;
                end else if (blank_q == BLANK_LAST) begin
                    advance = 1'b1;
                end else begin
                    blank_d = blank_q + 16'd1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            dwell_d = 16'd0;
            blank_d = 16'd0;
            pwm_d   = 4'd0;
        end

        // Start of the next digit's ON period: this is the only place the
        // shadow duty is refreshed, so brightness never changes mid-digit.
        if (advance) begin
            state_d   = ST_ON;
            dwell_d   = 16'd0;
            pwm_d     = 4'd0;
            duty_sh_d = duty_q;
            if (idx_q == LAST_IDX) begin
                idx_d        = 3'd0;
                frame_tick_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        // Outputs are registered from next-state values so they line up with
        // the state they describe.
        digit_sel_d = (state_d == ST_ON) ? (8'd1 << idx_d) : 8'd0;
        seg_on_d    = (state_d == ST_ON) && (pwm_d < duty_sh_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            en_q         <= 1'b0;
            duty_q       <= 4'd0;
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            dwell_q      <= 16'd0;
            blank_q      <= 16'd0;
            pwm_q        <= 4'd0;
            duty_sh_q    <= 4'd0;
            frame_cnt_q  <= 16'd0;
            digit_sel_q  <= 8'd0;
            seg_on_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            duty_q       <= duty_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            dwell_q      <= dwell_d;
            blank_q      <= blank_d;
            pwm_q        <= pwm_d;
            duty_sh_q    <= duty_sh_d;
            frame_cnt_q  <= frame_cnt_d;
            digit_sel_q  <= digit_sel_d;
            seg_on_q     <= seg_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        if (Addr) begin
            data_return_cpu = {frame_cnt_q, 8'b0, 3'b0, state_q, idx_q};
        end else begin
            data_return_cpu = {24'b0, duty_q, 3'b0, en_q};
        end
    end

    assign digit_idx  = idx_q;
    assign digit_sel  = digit_sel_q;
    assign seg_on     = seg_on_q;
    assign frame_tick = frame_tick_q;

    // Write-data bits with no CTRL field behind them.
    logic unused_data;
    assign unused_data = ^{data_in[31:8], data_in[3:1]};

endmodule

// File: tb/tb_digital_scan_ctrl.sv
// Self-checking bench for digital_scan_ctrl. Several instances with different
// DIGITS/DWELL/BLANK share one bus; a frame-position model predicts every
// output of every instance each cycle, and directed sections pin the model
// with hand-derived expectations.

module tb_digital_scan_ctrl;

    localparam int NI = 5;

    function automatic int unsigned pd(input int i);
        case (i)
            3: return 8;
            4: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned pw(input int i);
        case (i)
            1: return 20;
            3: return 1;
            4: return 17;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned pb(input int i);
        case (i)
            2: return 0;
            3: return 1;
            4: return 3;
            default: return 2;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] data_in = 32'd0;

    logic [31:0] rd_w   [NI];
    logic [2:0]  idx_w  [NI];
    logic [7:0]  sel_w  [NI];
    logic        seg_w  [NI];
    logic        tick_w [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        digital_scan_ctrl #(
            .DIGITS(pd(g)),
            .DWELL (pw(g)),
            .BLANK (pb(g))
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .enable         (enable),
            .Addr           (addr),
            .data_in        (data_in),
            .data_return_cpu(rd_w[g]),
            .digit_idx      (idx_w[g]),
            .digit_sel      (sel_w[g]),
            .seg_on         (seg_w[g]),
            .frame_tick     (tick_w[g])
        );
    end

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A running scan is a position p within a frame of DIGITS*(DWELL+BLANK)
    // cycles; everything visible is derived from p arithmetically.
    bit          m_run  [NI];
    int          m_p    [NI];
    logic [3:0]  m_duty [NI];
    logic [15:0] m_fcnt [NI];
    bit          m_tick [NI];
    bit          m_en;
    logic [3:0]  m_dreg;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                m_run[i]  = 1'b0;
                m_p[i]    = 0;
                m_duty[i] = 4'd0;
                m_fcnt[i] = 16'd0;
                m_tick[i] = 1'b0;
            end
            m_en   = 1'b0;
            m_dreg = 4'd0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_tick[i] = 1'b0;
                if (!m_run[i]) begin
                    if (m_en) begin
                        m_run[i]  = 1'b1;
                        m_p[i]    = 0;
                        m_duty[i] = m_dreg;
                    end
                end else if (!m_en) begin
                    m_run[i] = 1'b0;
                    m_p[i]   = 0;
                end else begin
                    m_p[i] = (m_p[i] + 1) % int'(pd(i) * (pw(i) + pb(i)));
                    if (m_p[i] % int'(pw(i) + pb(i)) == 0) m_duty[i] = m_dreg;
                    if (m_p[i] == 0) begin
                        m_tick[i] = 1'b1;
                        m_fcnt[i] = m_fcnt[i] + 16'd1;
                    end
                end
            end
            if (enable && !addr) begin
                m_en   = data_in[0];
                m_dreg = data_in[7:4];
            end
        end
    end

    function automatic void exp_out(input int i, output logic [7:0] sel, output logic [2:0] idx,
                                    output logic [1:0] st, output logic seg);
        int slot_len;
        int s;
        int off;
        sel = 8'd0; idx = 3'd0; st = 2'd0; seg = 1'b0;
        if (m_run[i]) begin
            slot_len = int'(pw(i) + pb(i));
            s   = m_p[i] / slot_len;
            off = m_p[i] % slot_len;
            idx = 3'(s);
            if (off < int'(pw(i))) begin
                st  = 2'd1;
                sel = 8'(1 << s);
                seg = ((off % 16) < int'(m_duty[i]));
            end else begin
                st = 2'd2;
            end
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                logic [7:0]  es;
                logic [2:0]  ei;
                logic [1:0]  est;
                logic        eg;
                logic [31:0] erd;
                exp_out(i, es, ei, est, eg);
                erd = addr ? {m_fcnt[i], 8'b0, 3'b0, est, ei} : {24'b0, m_dreg, 3'b0, m_en};
                check($sformatf("sel[%0d]", i), 32'(sel_w[i]), 32'(es));
                check($sformatf("idx[%0d]", i), 32'(idx_w[i]), 32'(ei));
                check($sformatf("seg[%0d]", i), 32'(seg_w[i]), 32'(eg));
                check($sformatf("tick[%0d]", i), 32'(tick_w[i]), 32'(m_tick[i]));
                check($sformatf("rd[%0d]", i), rd_w[i], erd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        enable  = 1'b1;
        addr    = a;
        data_in = d;
        cyc();
        enable  = 1'b0;
        data_in = 32'd0;
    endtask

    logic [7:0] log_sel0 [64];
    logic [2:0] log_idx0 [64];
    logic       log_seg0 [64];
    logic       log_tck0 [64];
    logic [7:0] log_sel2 [64];
    logic       log_tck2 [64];
    logic       log_seg1 [64];

    initial begin
        bit          found;
        logic [15:0] fexp;
        logic [31:0] d;
        int          r;

        repeat (3) cyc();
        reset  = 1'b0;
        chk_on = 1'b1;

        // Idle after reset: nothing lit, both read words zero.
        for (int k = 0; k < 50; k++) begin
            addr = k[0];
            #1;
            check("idle_sel", 32'(sel_w[0]), 32'd0);
            check("idle_seg", 32'(seg_w[0]), 32'd0);
            check("idle_rd", rd_w[0], 32'd0);
            cyc();
        end
        addr = 1'b0;

        // Full-brightness scan start; edge T is the write edge.
        wr(1'b0, 32'h0000_00F1);
        for (int k = 1; k <= 26; k++) begin
            cyc();
            log_sel0[k] = sel_w[0];
            log_idx0[k] = idx_w[0];
            log_seg0[k] = seg_w[0];
            log_tck0[k] = tick_w[0];
            log_sel2[k] = sel_w[2];
            log_tck2[k] = tick_w[2];
        end
        for (int k = 1; k <= 4; k++) begin
            check("t2_sel_d0", 32'(log_sel0[k]), 32'h1);
            check("t2_idx_d0", 32'(log_idx0[k]), 32'h0);
            check("t2_seg_d0", 32'(log_seg0[k]), 32'h1);
        end
        check("t2_blank5", 32'(log_sel0[5]), 32'h0);
        check("t2_blank6", 32'(log_sel0[6]), 32'h0);
        check("t2_sel_d1", 32'(log_sel0[7]), 32'h2);
        for (int k = 1; k <= 26; k++) check($sformatf("t2_tick@%0d", k), 32'(log_tck0[k]), 32'(k == 25));
        // BLANK=0 instance: back-to-back digits, 16-cycle frame.
        check("t5_sel1", 32'(log_sel2[1]), 32'h1);
        check("t5_sel2", 32'(log_sel2[5]), 32'h2);
        check("t5_sel3", 32'(log_sel2[9]), 32'h4);
        check("t5_sel4", 32'(log_sel2[13]), 32'h8);
        check("t5_sel5", 32'(log_sel2[16]), 32'h8);
        check("t5_wrap", 32'(log_sel2[17]), 32'h1);
        check("t5_tick1", 32'(log_tck2[1]), 32'h0);
        check("t5_tick16", 32'(log_tck2[16]), 32'h0);
        check("t5_tick17", 32'(log_tck2[17]), 32'h1);

        wr(1'b0, 32'h0);
        repeat (3) cyc();

        // Duty 2 on DWELL=20 instance, then duty 8 written mid-digit at T+5.
        wr(1'b0, 32'h0000_0021);
        for (int k = 1; k <= 44; k++) begin
            if (k == 5) begin
                enable = 1'b1; addr = 1'b0; data_in = 32'h0000_0081;
            end else begin
                enable = 1'b0; data_in = 32'h0;
            end
            cyc();
            log_seg1[k] = seg_w[1];
        end
        enable = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            logic e;
            if (k <= 20)      e = (k == 1 || k == 2 || k == 17 || k == 18);
            else if (k <= 22) e = 1'b0;
            else if (k <= 42) e = (((k - 23) % 16) < 8);
            else              e = 1'b0;
            check($sformatf("t3_seg@%0d", k), 32'(log_seg1[k]), 32'(e));
        end
        addr = 1'b0;
        #1;
        check("t4_ctrl_rd", rd_w[1], 32'h0000_0081);

        // Stop while instance 0 is on digit 2; frame count must survive.
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_run[0] && (m_p[0] / 6) == 2 && (m_p[0] % 6) == 1) found = 1'b1;
            else cyc();
        end
        check("wait_idx2", 32'(found), 32'h1);
        fexp = m_fcnt[0];
        wr(1'b0, 32'h0);
        cyc();
        addr = 1'b1;
        #1;
        check("t6_sel_off", 32'(sel_w[0]), 32'h0);
        check("t6_status_lo", rd_w[0] & 32'h1F, 32'h0);
        check("t6_fcnt_held", 32'(rd_w[0][31:16]), 32'(fexp));

        // Reset in the middle of a blank interval.
        wr(1'b0, 32'h0000_0051);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_run[0] && (m_p[0] % 6) == 4) found = 1'b1;
            else cyc();
        end
        check("wait_blk", 32'(found), 32'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        addr  = 1'b1;
        #1;
        check("t6_rst_status", rd_w[0], 32'h0);
        repeat (10) cyc();
        check("t6_no_resume", 32'(sel_w[0]), 32'h0);

        // Randomised bus traffic, checked every cycle by the model.
        for (int k = 0; k < 4000; k++) begin
            r       = int'($urandom_range(0, 199));
            enable  = 1'b0;
            reset   = 1'b0;
            data_in = 32'h0;
            addr    = 1'($urandom_range(0, 1));
            if (r < 8) begin
                d       = $urandom;
                d[0]    = ($urandom_range(0, 4) != 0);
                enable  = 1'b1;
                addr    = 1'b0;
                data_in = d;
            end else if (r < 12) begin
                enable  = 1'b1;
                addr    = 1'b1;
                data_in = $urandom;
            end else if (r == 12) begin
                reset = 1'b1;
            end else if (r == 13 && !m_en) begin
                enable  = 1'b1;
                addr    = 1'b0;
                data_in = {24'h0, 4'($urandom), 4'h1};
            end
            cyc();
        end
        enable = 1'b0;
        reset  = 1'b0;
        cyc();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
